// File: rtl/agc_timing_pkg.sv
// ---------------------------------------------------------------------------
// agc_timing_pkg
// Shared definitions for the AGC timepulse generator:
//   - tp_state_e : run/stop/step FSM state encoding
//   - *_DEF      : default geometry (timepulses, phases, clock divider)
//   - cnt_width  : counter width for a modulo-N counter, never narrower than 1
// ---------------------------------------------------------------------------
package agc_timing_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STOPPING = 2'd1,
        ST_STOPPED  = 2'd2,
        ST_STEP     = 2'd3
    } tp_state_e;

    localparam int N_TP_DEF = 12;
    localparam int N_PH_DEF = 4;
    localparam int DIV_DEF  = 2;

    // A modulo-1 counter still needs one storage bit so that port widths
    // stay legal; it simply never leaves 0.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/agc_mod_counter.sv
// ---------------------------------------------------------------------------
// agc_mod_counter
// Modulo-MOD counter used for the divider, phase and timepulse stages.
// Ports:
//   SIM_CLK  in   clock, rising edge
//   RESET_   in   synchronous active-low reset
//   clr      in   synchronous clear to 0 (dominates en)
//   en       in   advance by one, wrapping MOD-1 -> 0
//   cnt      out  current count
//   wrap     out  en && cnt == MOD-1 (carry into the next stage)
// ---------------------------------------------------------------------------
module agc_mod_counter
    import agc_timing_pkg::*;
#(
    parameter int MOD = 2
) (
    input  logic                       SIM_CLK,
    input  logic                       RESET_,
    input  logic                       clr,
    input  logic                       en,
    output logic [cnt_width(MOD)-1:0]  cnt,
    output logic                       wrap
);

    localparam int             W       = cnt_width(MOD);
    localparam logic [W-1:0]   CNT_MAX = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = en && (cnt_q == CNT_MAX);
    assign cnt  = cnt_q;

    // NOTE: combinational blocks assign a default first so no path leaves
    // cnt_d unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge SIM_CLK) begin
        if (!RESET_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/agc_tpgen.sv
// ---------------------------------------------------------------------------
// agc_tpgen
// Parametrised timepulse generator: divides SIM_CLK into phases and phases
// into timepulses, producing one-hot TP/PHS strobes per memory cycle time
// (MCT), with run/stop, monitor single-step and GOJAM restart.
// Ports:
//   SIM_CLK    in   sole clock
//   RESET_     in   synchronous active-low reset
//   GOJAM_     in   active-low restart to the start of an MCT
//   STOP_REQ   in   request halt at the next MCT end
//   MSTP       in   monitor single-step mode
//   STEP_REQ   in   rising edge while stopped in MSTP runs one MCT
//   TP         out  one-hot timepulse, TP[0] = T01
//   PHS        out  one-hot phase within the timepulse
//   MCT_END    out  pulse on the last cycle of an MCT
//   TLAST_SET  out  pulse on the first cycle of the last timepulse
//   STOPPED    out  high while halted
//   MCT_COUNT  out  16-bit MCT counter (only with AGC_TPGEN_MCTCNT_EN)
// Configuration macro: AGC_TPGEN_MCTCNT_EN adds the MCT_COUNT port.
// ---------------------------------------------------------------------------
module agc_tpgen
    import agc_timing_pkg::*;
#(
    parameter int N_TP = N_TP_DEF,
    parameter int N_PH = N_PH_DEF,
    parameter int DIV  = DIV_DEF
) (
    input  logic             SIM_CLK,
    input  logic             RESET_,
    input  logic             GOJAM_,
    input  logic             STOP_REQ,
    input  logic             MSTP,
    input  logic             STEP_REQ,
    output logic [N_TP-1:0]  TP,
    output logic [N_PH-1:0]  PHS,
    output logic             MCT_END,
    output logic             TLAST_SET,
    output logic             STOPPED
`ifdef AGC_TPGEN_MCTCNT_EN
    ,
    output logic [15:0]      MCT_COUNT
`endif
);

    localparam int DW = cnt_width(DIV);
    localparam int PW = cnt_width(N_PH);
    localparam int TW = cnt_width(N_TP);

    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [PW-1:0] PH_MAX  = PW'(N_PH - 1);
    localparam logic [TW-1:0] TP_MAX  = TW'(N_TP - 1);

    tp_state_e       state_q, state_d;
    logic [N_TP-1:0] tp_q, tp_d;
    logic [N_PH-1:0] phs_q, phs_d;
    logic            mct_end_q, mct_end_d;
    logic            tlast_q, tlast_d;
    logic            stopped_q, stopped_d;
    logic            step_prev_q, step_prev_d;

    logic [DW-1:0]   div_cnt, div_n;
    logic [PW-1:0]   ph_cnt, ph_n;
    logic [TW-1:0]   tp_cnt, tp_n;
    logic            div_wrap, ph_wrap, tp_wrap;
    logic            cnt_clr, cnt_en;
    logic            stop_any, step_rise;

    assign stop_any    = STOP_REQ | MSTP;
    assign step_rise   = STEP_REQ & ~step_prev_q;
    assign step_prev_d = STEP_REQ;

    // The counters hold the position currently shown on TP/PHS. They only
    // advance once a position is actually on display, so leaving reset or
    // STOPPED shows position 0 for a full cycle before moving on.
    assign cnt_en  = |tp_q;
    assign cnt_clr = !GOJAM_ || (state_d == ST_STOPPED);

    agc_mod_counter #(.MOD(DIV)) u_div (
        .SIM_CLK (SIM_CLK), .RESET_ (RESET_), .clr (cnt_clr),
        .en      (cnt_en),  .cnt    (div_cnt), .wrap (div_wrap)
    );

    agc_mod_counter #(.MOD(N_PH)) u_ph (
        .SIM_CLK (SIM_CLK), .RESET_ (RESET_), .clr (cnt_clr),
        .en      (div_wrap), .cnt   (ph_cnt), .wrap (ph_wrap)
    );

    agc_mod_counter #(.MOD(N_TP)) u_tp (
        .SIM_CLK (SIM_CLK), .RESET_ (RESET_), .clr (cnt_clr),
        .en      (ph_wrap), .cnt    (tp_cnt), .wrap (tp_wrap)
    );

    // Next-state logic. MCT_END is judged from the registered pulse, i.e. the
    // decision is taken on the edge that closes the last cycle of the MCT.
    always_comb begin
        state_d = state_q;
        if (!GOJAM_) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stop_any) state_d = ST_STOPPING;
                end
                ST_STOPPING: begin
                    if (!stop_any)      state_d = ST_RUN;
                    else if (mct_end_q) state_d = ST_STOPPED;
                end
                ST_STOPPED: begin
                    if (!stop_any)                           state_d = ST_RUN;
                    else if (MSTP && !STOP_REQ && step_rise) state_d = ST_STEP;
                end
                ST_STEP: begin
                    if (mct_end_q) state_d = MSTP ? ST_STOPPED : ST_RUN;
                end
            endcase
        end
    end

    // Position the counters take on this edge; the outputs register a decode
    // of it so they line up with the counters in the following cycle.
    always_comb begin
        div_n = div_cnt;
        ph_n  = ph_cnt;
        tp_n  = tp_cnt;
        if (cnt_clr) begin
            div_n = '0;
            ph_n  = '0;
            tp_n  = '0;
        end else begin
            if (div_wrap)    div_n = '0;
            else if (cnt_en) div_n = div_cnt + DW'(1);
            if (ph_wrap)       ph_n = '0;
            else if (div_wrap) ph_n = ph_cnt + PW'(1);
            if (tp_wrap)      tp_n = '0;
            else if (ph_wrap) tp_n = tp_cnt + TW'(1);
        end
    end

    always_comb begin
        stopped_d = (state_d == ST_STOPPED);
        tp_d      = '0;
        phs_d     = '0;
        mct_end_d = 1'b0;
        tlast_d   = 1'b0;
        if (!stopped_d) begin
            tp_d      = N_TP'(1) << tp_n;
            phs_d     = N_PH'(1) << ph_n;
            mct_end_d = (div_n == DIV_MAX) && (ph_n == PH_MAX) && (tp_n == TP_MAX);
            tlast_d   = (div_n == '0) && (ph_n == '0) && (tp_n == TP_MAX);
        end
    end

    // NOTE: every flop here, including the FSM state, is cleared by the
    // synchronous reset so no output is X after the first reset edge.
    always_ff @(posedge SIM_CLK) begin
        if (!RESET_) begin
            state_q     <= ST_RUN;
            tp_q        <= '0;
            phs_q       <= '0;
            mct_end_q   <= 1'b0;
            tlast_q     <= 1'b0;
            stopped_q   <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tp_q        <= tp_d;
            phs_q       <= phs_d;
            mct_end_q   <= mct_end_d;
            tlast_q     <= tlast_d;
            stopped_q   <= stopped_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign TP        = tp_q;
    assign PHS       = phs_q;
    assign MCT_END   = mct_end_q;
    assign TLAST_SET = tlast_q;
    assign STOPPED   = stopped_q;

`ifdef AGC_TPGEN_MCTCNT_EN
    logic [15:0] mct_count_q, mct_count_d;

    // Counts completed MCTs; the increment lands the cycle after MCT_END.
    always_comb begin
        mct_count_d = mct_count_q;
        if (!GOJAM_) begin
            mct_count_d = '0;
        end else if (mct_end_q) begin
            mct_count_d = mct_count_q + 16'd1;
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (!RESET_) begin
            mct_count_q <= '0;
        end else begin
            mct_count_q <= mct_count_d;
        end
    end

    assign MCT_COUNT = mct_count_q;
`endif

endmodule

// File: tb/tb_agc_tpgen.sv
// ---------------------------------------------------------------------------
// tb_agc_tpgen
// Drives a default-geometry generator (12x4x2) and a small one (5x2x3) from
// the same stimulus. A reference model tracks each MCT as a single position
// integer; its expected outputs are queued at every rising edge and a monitor
// pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_agc_tpgen;

    localparam int A_NTP = 12, A_NPH = 4, A_DIV = 2;
    localparam int B_NTP = 5,  B_NPH = 2, B_DIV = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0, gojam_n = 1'b1, stop_req = 1'b0, mstp = 1'b0, step_req = 1'b0;

    logic [A_NTP-1:0] tp_a;
    logic [A_NPH-1:0] phs_a;
    logic             mct_end_a, tlast_a, stopped_a;
    logic [B_NTP-1:0] tp_b;
    logic [B_NPH-1:0] phs_b;
    logic             mct_end_b, tlast_b, stopped_b;
`ifdef AGC_TPGEN_MCTCNT_EN
    logic [15:0]      cnt_a, cnt_b;
`endif

    agc_tpgen #(.N_TP(A_NTP), .N_PH(A_NPH), .DIV(A_DIV)) dut_a (
        .SIM_CLK (clk), .RESET_ (reset_n), .GOJAM_ (gojam_n),
        .STOP_REQ (stop_req), .MSTP (mstp), .STEP_REQ (step_req),
        .TP (tp_a), .PHS (phs_a), .MCT_END (mct_end_a),
        .TLAST_SET (tlast_a), .STOPPED (stopped_a)
`ifdef AGC_TPGEN_MCTCNT_EN
        , .MCT_COUNT (cnt_a)
`endif
    );

    agc_tpgen #(.N_TP(B_NTP), .N_PH(B_NPH), .DIV(B_DIV)) dut_b (
        .SIM_CLK (clk), .RESET_ (reset_n), .GOJAM_ (gojam_n),
        .STOP_REQ (stop_req), .MSTP (mstp), .STEP_REQ (step_req),
        .TP (tp_b), .PHS (phs_b), .MCT_END (mct_end_b),
        .TLAST_SET (tlast_b), .STOPPED (stopped_b)
`ifdef AGC_TPGEN_MCTCNT_EN
        , .MCT_COUNT (cnt_b)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef enum int {M_RUN, M_STOPPING, M_STOPPED, M_STEP} mode_e;
    typedef struct {
        mode_e mode;
        int    pos;   // position within the MCT on display, -1 = none
        bit    prev;  // STEP_REQ seen at the previous edge
        int    cnt;   // completed MCTs
    } mdl_t;

    mdl_t        ma, mb;
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_obs(logic [31:0] tp, logic [7:0] phs, logic e,
                                             logic t, logic s, logic [15:0] c);
        return {5'b0, tp, phs, e, t, s, c};
    endfunction

    function automatic mdl_t model_next(mdl_t s, int ntp, int nph, int dv,
                                        bit r, bit g, bit sr, bit ms, bit st);
        mdl_t n;
        int   len;
        bit   end_now;
        n       = s;
        len     = ntp * nph * dv;
        end_now = (s.pos == len - 1);
        if (!r) begin
            n.mode = M_RUN; n.pos = -1; n.prev = 1'b0; n.cnt = 0;
            return n;
        end
        n.prev = st;
        if (!g) begin
            n.mode = M_RUN; n.pos = 0; n.cnt = 0;
            return n;
        end
        if (end_now) n.cnt = (s.cnt + 1) % 65536;
        case (s.mode)
            M_RUN:      if (sr || ms) n.mode = M_STOPPING;
            M_STOPPING: if (!sr && !ms) n.mode = M_RUN;
                        else if (end_now) n.mode = M_STOPPED;
            M_STOPPED:  if (!sr && !ms) n.mode = M_RUN;
                        else if (ms && !sr && st && !s.prev) n.mode = M_STEP;
            M_STEP:     if (end_now) n.mode = ms ? M_STOPPED : M_RUN;
        endcase
        if (n.mode == M_STOPPED) n.pos = -1;
        else                     n.pos = (s.pos < 0) ? 0 : (s.pos + 1) % len;
        return n;
    endfunction

    function automatic logic [63:0] model_out(mdl_t s, int ntp, int nph, int dv);
        logic [31:0] tp;
        logic [7:0]  phs;
        logic        e, t;
        logic [15:0] c;
        tp = '0; phs = '0; e = 1'b0; t = 1'b0;
        if (s.pos >= 0) begin
            tp  = 32'(1) << (s.pos / (dv * nph));
            phs = 8'(1) << ((s.pos / dv) % nph);
            e   = (s.pos == ntp * nph * dv - 1);
            t   = (s.pos == (ntp - 1) * nph * dv);
        end
`ifdef AGC_TPGEN_MCTCNT_EN
        c = 16'(s.cnt);
`else
        c = 16'd0;
`endif
        return pack_obs(tp, phs, e, t, s.mode == M_STOPPED, c);
    endfunction

    function automatic logic [63:0] obs_a();
        logic [15:0] c;
`ifdef AGC_TPGEN_MCTCNT_EN
        c = cnt_a;
`else
        c = 16'd0;
`endif
        return pack_obs(32'(tp_a), 8'(phs_a), mct_end_a, tlast_a, stopped_a, c);
    endfunction

    function automatic logic [63:0] obs_b();
        logic [15:0] c;
`ifdef AGC_TPGEN_MCTCNT_EN
        c = cnt_b;
`else
        c = 16'd0;
`endif
        return pack_obs(32'(tp_b), 8'(phs_b), mct_end_b, tlast_b, stopped_b, c);
    endfunction

    // Reference model: one step per rising edge, expectations queued.
    initial begin
        ma.mode = M_RUN; ma.pos = -1; ma.prev = 1'b0; ma.cnt = 0;
        mb = ma;
        forever begin
            @(posedge clk);
            cyc++;
            ma = model_next(ma, A_NTP, A_NPH, A_DIV, reset_n, gojam_n, stop_req, mstp, step_req);
            mb = model_next(mb, B_NTP, B_NPH, B_DIV, reset_n, gojam_n, stop_req, mstp, step_req);
            q_a.push_back(model_out(ma, A_NTP, A_NPH, A_DIV));
            q_b.push_back(model_out(mb, B_NTP, B_NPH, B_DIV));
        end
    end

    // Monitor: compare whatever the DUTs present against the queued model.
    initial begin
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                exp = q_a.pop_front();
                check($sformatf("sb_a_cyc%0d", cyc), obs_a(), exp);
            end
            if (q_b.size() > 0) begin
                exp = q_b.pop_front();
                check($sformatf("sb_b_cyc%0d", cyc), obs_b(), exp);
            end
        end
    end

    task automatic wait_stopped(input string name);
        for (int i = 0; i < 400 && !stopped_a; i++) @(negedge clk);
        check(name, 64'(stopped_a), 64'd1);
    endtask

    initial begin
        int  active;
        int  ends;
        bit  found;

        // Reset held for five edges: every output must read zero.
        repeat (5) @(negedge clk);
        check("rst_tp", 64'(tp_a), 64'd0);
        check("rst_stopped", 64'(stopped_a), 64'd0);
        reset_n = 1'b1;

        // Free run from reset: landmarks of the first MCTs.
        for (int k = 0; k <= 288; k++) begin
            @(negedge clk);
            if (k == 0)  begin
                check("first_tp", 64'(tp_a), 64'h001);
                check("first_phs", 64'(phs_a), 64'h1);
            end
            if (k == 8)   check("tp_at_8", 64'(tp_a), 64'h002);
            if (k == 88)  check("tlast_at_88", 64'(tlast_a), 64'd1);
            if (k == 95)  check("mct_end_at_95", 64'(mct_end_a), 64'd1);
            if (k == 96)  check("tp_at_96", 64'(tp_a), 64'h001);
            if (k == 24)  check("b_tlast_at_24", 64'(tlast_b), 64'd1);
            if (k == 29)  check("b_mct_end_at_29", 64'(mct_end_b), 64'd1);
            if (k == 59)  check("b_mct_end_at_59", 64'(mct_end_b), 64'd1);
`ifdef AGC_TPGEN_MCTCNT_EN
            if (k == 288) check("mct_count_3", 64'(cnt_a), 64'd3);
`endif
        end

        // Stop request, then restart.
        stop_req = 1'b1;
        wait_stopped("stop_reached");
        check("stopped_tp_zero", 64'(tp_a), 64'd0);
        stop_req = 1'b0;
        @(negedge clk);
        check("restart_tp", 64'(tp_a), 64'h001);

        // Monitor single-step: one pulse gives exactly one MCT.
        mstp = 1'b1;
        wait_stopped("mstp_stopped");
        step_req = 1'b1;
        active = 0; ends = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            step_req = 1'b0;
            if (tp_a != '0) active++;
            if (mct_end_a)  ends++;
            if (stopped_a)  break;
        end
        check("step_active_cycles", 64'(active), 64'd96);
        check("step_mct_ends", 64'(ends), 64'd1);

        // STEP_REQ held high must not re-trigger.
        step_req = 1'b1;
        ends = 0;
        repeat (300) begin
            @(negedge clk);
            if (mct_end_a) ends++;
        end
        step_req = 1'b0;
        check("step_held_ends", 64'(ends), 64'd1);
        mstp = 1'b0;

        // GOJAM in mid-MCT at T07.
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tp_a == 12'h040) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_t07", 64'(found), 64'd1);
        gojam_n = 1'b0;
        @(negedge clk);
        gojam_n = 1'b1;
        check("gojam_tp", 64'(tp_a), 64'h001);
        check("gojam_phs", 64'(phs_a), 64'h1);

        // GOJAM while stopped exits to RUN.
        stop_req = 1'b1;
        wait_stopped("stop_before_gojam");
        gojam_n = 1'b0;
        @(negedge clk);
        gojam_n  = 1'b1;
        stop_req = 1'b0;
        check("gojam_unstop", 64'(stopped_a), 64'd0);
        check("gojam_unstop_tp", 64'(tp_a), 64'h001);
`ifdef AGC_TPGEN_MCTCNT_EN
        check("gojam_count_clr", 64'(cnt_a), 64'd0);
`endif

        // Randomised control traffic; the scoreboard checks every cycle.
        repeat (4000) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 999) != 0);
            gojam_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 149) == 0) stop_req = ~stop_req;
            if ($urandom_range(0, 199) == 0) mstp     = ~mstp;
            if ($urandom_range(0, 19) == 0)  step_req = ~step_req;
        end

        reset_n = 1'b1; gojam_n = 1'b1; stop_req = 1'b0; mstp = 1'b0; step_req = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/agc_tpgen.md
Name: agc_tpgen

Overview:
- Parametrised successor to the fixed 12-timepulse timer.
- Divides SIM_CLK into phases, and phases into timepulses, to produce one-hot timepulse (TP) and phase (PHS) strobes for each memory cycle time (MCT).
- Adds run/stop control, monitor single-step and GOJAM restart; stops and steps land on MCT boundaries.
- Sits between the clock source and the sequence/control logic; replaces hardwired T01..T12 generation.

Parameters:
- N_TP, 12: timepulses per MCT (2..32).
- N_PH, 4: phases per timepulse (2..8).
- DIV, 2: SIM_CLK cycles per phase (1..16).

Ports:
- SIM_CLK  input  1  sole clock; all state updates on rising edge.
- RESET_  input  1  synchronous, active-low reset.
- GOJAM_  input  1  active-low restart; forces counters to the start of an MCT.
- STOP_REQ  input  1  level; requests halt at the next MCT end.
- MSTP  input  1  level; monitor single-step mode.
- STEP_REQ  input  1  level; a rising edge while stopped in MSTP runs exactly one MCT.
- TP  output  N_TP  one-hot timepulse; TP[0]=T01.
- PHS  output  N_PH  one-hot phase strobe within the current timepulse.
- MCT_END  output  1  1-cycle pulse on the last SIM_CLK cycle of an MCT.
- TLAST_SET  output  1  1-cycle pulse on the first cycle of the last timepulse (T12SET equivalent).
- STOPPED  output  1  high while halted.

Behaviour:
- Three cascaded modulo counters:
  - div: 0..DIV-1, advances every cycle while running.
  - ph: 0..N_PH-1, advances when div==DIV-1.
  - tp: 0..N_TP-1, advances when ph==N_PH-1 and div==DIV-1.
- Each counter wraps to 0. MCT length = DIV*N_PH*N_TP cycles; 96 at defaults.
- All outputs are registered. While running: TP=1<<tp, PHS=1<<ph.
- MCT_END is high when div, ph and tp are all at their maxima.
- TLAST_SET is high when tp==N_TP-1, ph==0 and div==0.
- FSM states:
  - RUN: free-running. If STOP_REQ or MSTP is high, go to STOPPING.
  - STOPPING: counters keep running. When MCT_END is high and STOP_REQ or MSTP is still high, go to STOPPED. If both are low, return to RUN with no interruption.
  - STOPPED: counters held at 0; TP=0, PHS=0, STOPPED=1.
    - If STOP_REQ=0 and MSTP=0, go to RUN.
    - Else if MSTP=1, STOP_REQ=0 and a STEP_REQ rising edge is detected (registered previous value), go to STEP.
  - STEP: one full MCT from tp=0. On MCT_END, go to STOPPED if MSTP=1, else go to RUN.
- STOPPED→RUN and STOPPED→STEP: the first output cycle is TP[0], PHS[0], div=0.
- STEP_REQ edges outside STOPPED are ignored; STEP_REQ held high does not re-trigger.
- Priority, highest first: RESET_=0, then GOJAM_=0, then FSM.
- GOJAM_=0:
  - Counters reset to 0 and state becomes RUN, from any state including mid-MCT and STOPPED.
  - Outputs show TP[0], PHS[0] on the next cycle.
  - While held low, outputs stay at TP[0], PHS[0] with counters frozen.
  - STOP_REQ/MSTP are re-evaluated on the first cycle after release.
- Reset:
  - While RESET_=0: all outputs 0 (TP, PHS, MCT_END, TLAST_SET, STOPPED), counters 0, state RUN, STEP_REQ edge register 0.
  - First edge with RESET_=1 loads TP[0], PHS[0].
  - Reset mid-MCT aborts the MCT immediately.
- Simultaneous STOP_REQ rise and MCT_END while in RUN: transition to STOPPING only; halt at the following MCT end.
- DIV=1: every cycle advances ph, so PHS rotates each cycle.

Optional Feature:
- Macro: AGC_TPGEN_MCTCNT_EN.
- Defined: adds output MCT_COUNT [15:0].
  - Reset to 0; +1 on each MCT_END; wraps at 16'hFFFF→0.
  - Cleared by GOJAM_=0; held while STOPPED.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package agc_timing_pkg holds:
  - FSM state encoding: RUN=2'd0, STOPPING=2'd1, STOPPED=2'd2, STEP=2'd3.
  - Counter-width helper constants derived via $clog2 of DIV, N_PH and N_TP.
- Sub-module agc_mod_counter (parameter MOD), instantiated three times:
  - Ports: SIM_CLK, RESET_, clr, en, cnt, wrap.
  - wrap = en && cnt==MOD-1.
- The FSM and output decode stay in agc_tpgen.

Test Plan:
- Defaults, RESET_ low 5 cycles then high: TP=0x001/PHS=0x1 on the first cycle. TP=0x002 at cycle 8. TLAST_SET at cycle 88. MCT_END at cycle 95. TP=0x001 at cycle 96.
- STOP_REQ raised at cycle 30: STOPPED=1 and TP=0 from cycle 96. Lower STOP_REQ: TP=0x001 on the next cycle, MCT restarts cleanly.
- MSTP=1 until stopped, then one STEP_REQ pulse: exactly 96 cycles of TP activity, MCT_END once, back to STOPPED. STEP_REQ held high 300 cycles: only one MCT.
- GOJAM_ low for 1 cycle at cycle 50 (TP=0x040): next cycle TP=0x001, PHS=0x1, div=0. Repeat while STOPPED: exits to RUN.
- N_TP=5, N_PH=2, DIV=3: MCT_END period 30 cycles. TLAST_SET at cycle 24 of each MCT. One-hot checked every cycle.
- AGC_TPGEN_MCTCNT_EN defined: MCT_COUNT=3 after 288 running cycles; unchanged while STOPPED; 0 after GOJAM_.
